buf_reader_stream: RTL

Downstream companion of the frame-buffer updaters. On request it reads one complete frame, `IMG_WIDTH*IMG_HEIGHT` words, from the buffer selected by `buf_id` over a Wishbone master port. It presents the pixels in raster order on a valid/ready stream to the LED output driver. A small prefetch FIFO decouples memory latency from the driver's consumption rate.

---
 rtl/buf_reader_stream_pkg.sv | 20 ++
 rtl/buf_reader_stream_fifo.sv | 53 +++++
 rtl/buf_reader_stream.sv | 107 ++++++++++
 3 files changed

// File: rtl/buf_reader_stream_pkg.sv
// Shared frame geometry, buffer base-address mapping and reader state encoding.
package buf_reader_stream_pkg;

  localparam int IMG_WIDTH  = 4;
  localparam int IMG_HEIGHT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Each frame buffer occupies its own 4 KiB window.
  function automatic logic [31:0] addr_for_buf_id(input logic [31:0] id);
    return id << 12;
  endfunction

endpackage

// File: rtl/buf_reader_stream_fifo.sv
// Prefetch FIFO between the Wishbone fetch side and the pixel stream.
module pix_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/buf_reader_stream.sv
// Reads one frame over Wishbone and streams its pixels in raster order.
module buf_reader_stream
  import buf_reader_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  input  logic [DATA_WIDTH-1:0] buf_id,
  input  logic                  read_buf,
  output logic                  buf_read,
  output logic                  busy,
  output logic [23:0]           pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] TOTAL  = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST   = TOTAL - 1'b1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_fetch_cnt, r_pop_cnt;
  logic                  w_strobe, w_push, w_pop, w_flush;
  logic [24:0]           w_head;
  logic [CW-1:0]         w_count;
  logic                  w_empty, w_full, w_unused;

  // Room is only re-evaluated between accesses: the count cannot grow while
  // a read is in flight, so strobe naturally holds until its ack.
  assign w_strobe = (r_state == ST_FETCH) && (r_fetch_cnt < TOTAL) &&
                    (w_count < CW'(FIFO_DEPTH));
  assign w_push   = w_strobe && wbm_ack;
  assign w_pop    = !w_empty && pix_ready;
  assign w_flush  = (r_state == ST_INIT);
  assign w_unused = ^{wbm_readdata[DATA_WIDTH-1:24], w_full};

  pix_fifo #(.W(25), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({r_fetch_cnt == LAST, wbm_readdata[23:0]}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (read_buf) w_state_nxt = ST_INIT;
      ST_INIT:  w_state_nxt = ST_FETCH;
      ST_FETCH: if (r_fetch_cnt == TOTAL) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_pop_cnt == TOTAL) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_fetch_cnt <= '0;
      r_pop_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_addr      <= ADDR_WIDTH'(addr_for_buf_id(32'(buf_id)));
        r_fetch_cnt <= '0;
        r_pop_cnt   <= '0;
      end else begin
        if (w_push) begin
          r_addr      <= r_addr + STRIDE;
          r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
        if (w_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
      end
    end
  end

  assign wbm_address   = r_addr;
  assign wbm_writedata = '0;
  assign wbm_write     = 1'b0;
  assign wbm_strobe    = w_strobe;
  assign wbm_cycle     = w_strobe;
  assign busy          = (r_state != ST_IDLE);
  assign buf_read      = (r_state == ST_DONE);
  assign pix_valid     = !w_empty;
  assign pix_data      = w_empty ? 24'd0 : w_head[23:0];
  // The spare FIFO bit tags the entry fetched as pixel TOTAL-1.
  assign pix_last      = !w_empty && w_head[24];

endmodule
